beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Output-side counterpart to the front-panel button path: where the button path turns a noisy level into clean single-cycle events, this block turns a single-cycle request into a timed, human-perceptible level. On a one-cycle `start` it drives the microwave buzzer for a requested number of beeps, each with a fixed on-time and off-time. It sits between the cooking-control FSM (timer-expired, key-accept events) and the buzzer pin, and reports `busy`/`done` back to the controller.

## Interface
- `ON_CYCLES`, default 50_000_000: buzzer-on duration per beep, in clk cycles; must be ≥1.
- `OFF_CYCLES`, default 25_000_000: silent gap between beeps, in clk cycles; must be ≥1.
- `TONE_HALF`, default 25_000: tone half-period in cycles; used only with `BEEP_TONE_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request pulse.
- `count`  in  4  number of beeps, sampled with `start`; 0 = no-op.
- `cancel`  in  1  one-cycle abort pulse.
- `buzzer`  out  1  buzzer drive, registered.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes normally.

## Operation
- FSM states: IDLE, ON, OFF. Internal: phase counter sized with `$clog2(max(ON_CYCLES,OFF_CYCLES))` bits, 4-bit beeps-remaining register.
- IDLE: `start`=1 and `count`≠0 → latch `count`, load phase counter, go ON. `start` with `count`=0 → stay IDLE, no `done`.
- ON: `buzzer`=1. When phase counter expires: if beeps remaining = 1 → IDLE with `done` pulse; else decrement remaining, go OFF.
- OFF: `buzzer`=0. When phase counter expires → ON.
- `start` while not IDLE is ignored; `count` is not re-sampled.
- `cancel` in any non-IDLE state → IDLE next cycle, `buzzer`=0, no `done`. `cancel` in IDLE has no effect.
- `cancel` and `start` in the same IDLE cycle: `cancel` wins and the sequence does not start.
- `busy` = (state ≠ IDLE). No trailing OFF after the last beep.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, counters 0, `buzzer`=0, `busy`=0, `done`=0.
- `start` sampled at edge k → `buzzer` and `busy` high from cycle k+1.
- Each ON phase lasts exactly `ON_CYCLES` cycles; each OFF phase lasts exactly `OFF_CYCLES` cycles.
- For N beeps, `busy` is high for N·ON_CYCLES + (N−1)·OFF_CYCLES cycles. `done` is high for the first cycle after that window, in which `busy`=0 and `buzzer`=0.
- A new `start` is accepted in the same cycle `done` is high (state is already IDLE).
- `cancel` sampled at edge c → `buzzer`=`busy`=0 in cycle c+1.
- Reset asserted mid-sequence clears immediately. After reset deasserts, the block waits for a fresh `start`.

## Configuration
- `BEEP_TONE_EN` defined: during ON, `buzzer` is a square wave with period 2·`TONE_HALF` cycles. The wave starts high at ON entry and restarts on every ON entry. `buzzer` is 0 during OFF and IDLE. Use this for a passive piezo.
- `BEEP_TONE_EN` undefined: `buzzer` is a steady level during ON and 0 otherwise (active buzzer). `TONE_HALF` is unused, and no tone logic is synthesized.

## Structure
- Shared package `beep_pkg`: state enum (IDLE/ON/OFF), `BEEP_CNT_W`=4, and default ON/OFF constants for a 100 MHz clock.
- One sub-module, `tone_gen`: clk, rst, enable, and a square-wave output. It is instantiated only under `BEEP_TONE_EN`, and is held in reset while enable=0.

## Test plan
Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, TONE_HALF=1.
- `start` with `count`=1 → `buzzer` high for exactly 4 cycles starting at k+1; `busy` matches; `done` pulses at k+5.
- `start` with `count`=3 → `buzzer` pattern 1111 000 1111 000 1111; `busy` high for 18 cycles; single `done` at k+19.
- `start` with `count`=0 → `busy`, `buzzer` and `done` stay 0.
- `count`=3 run, then `start` with `count`=5 at cycle k+6 → ignored; total run still 18 cycles. A `start` in the `done` cycle → new sequence begins in the next cycle.
- `cancel` at cycle k+2 of a `count`=2 run → `buzzer`/`busy` 0 at k+3, no `done`. Simultaneous `start`+`cancel` in IDLE → nothing starts.
- `rst` driven low mid-OFF → outputs 0 immediately (asynchronously). With `BEEP_TONE_EN`, ON phases show 1,0,1,0 on `buzzer`.

Source files
------------

// File: rtl/beep_pkg.sv
// beep_pkg: shared types and default timing constants for the buzzer sequencer.
package beep_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam int BEEP_CNT_W     = 4;
    localparam int DEF_ON_CYCLES  = 50_000_000;
    localparam int DEF_OFF_CYCLES = 25_000_000;
    localparam int DEF_TONE_HALF  = 25_000;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave for a passive piezo; starts high when enabled, cleared while disabled.
module tone_gen #(
    parameter int TONE_HALF = 25_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic wave
);

    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [TW-1:0] cnt;
    logic          run;

    // First enabled edge raises the wave, then it toggles every TONE_HALF cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            run  <= 1'b0;
            wave <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            run  <= 1'b0;
            wave <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            run  <= 1'b1;
            wave <= 1'b1;
        end else if (cnt == TW'(TONE_HALF - 1)) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: plays count beeps of ON_CYCLES on / OFF_CYCLES off; BEEP_TONE_EN selects a piezo tone.
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int TONE_HALF  = DEF_TONE_HALF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BEEP_CNT_W-1:0] count,
    input  logic                  cancel,
    output logic                  buzzer,
    output logic                  busy,
    output logic                  done
);

    localparam int PMAX = imax(ON_CYCLES, OFF_CYCLES);
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TONE_HALF < 1) begin : g_bad_param
        $error("beep_sequencer: ON_CYCLES, OFF_CYCLES and TONE_HALF must be >= 1");
    end

    state_t                state, state_nx;
    logic [PW-1:0]         phase;
    logic [BEEP_CNT_W-1:0] remain;
    logic                  expire, done_nx, buzzer_nx;

    assign expire = (phase == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state: cancel beats everything, the last ON phase returns straight to IDLE
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (start && count != '0 && !cancel) ? ON : IDLE;
        else if (cancel)
            state_nx = IDLE;
        else if (expire)
            state_nx = (state == OFF) ? ON : ((remain == BEEP_CNT_W'(1)) ? IDLE : OFF);
    end

    // Outputs: leaving ON without cancel is a normal completion
    always_comb begin
        busy      = (state != IDLE);
        done_nx   = (state == ON) && (state_nx == IDLE) && !cancel;
        buzzer_nx = (state_nx == ON);
    end

    // Phase counter reloads on each phase entry; beeps-remaining counts down per ON->OFF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            remain <= '0;
            done   <= 1'b0;
        end else begin
            phase  <= (state_nx == ON  && state != ON)  ? PW'(ON_CYCLES - 1)  :
                      (state_nx == OFF && state != OFF) ? PW'(OFF_CYCLES - 1) :
                      (state_nx == IDLE)                ? '0 : phase - 1'b1;
            remain <= (state == IDLE && state_nx == ON) ? count :
                      (state == ON && state_nx == OFF)  ? remain - 1'b1 :
                      (state_nx == IDLE)                ? '0 : remain;
            done   <= done_nx;
        end
    end

`ifdef BEEP_TONE_EN
    tone_gen #(.TONE_HALF(TONE_HALF)) u_tone (
        .clk    (clk),
        .rst    (rst),
        .enable (buzzer_nx),
        .wave   (buzzer)
    );
`else
    // Steady drive for an active buzzer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) buzzer <= 1'b0;
        else      buzzer <= buzzer_nx;
    end
`endif

endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: directed scoreboard bench; expected {buzzer,busy,done} per cycle queued ahead of stimulus.
module tb_beep_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       cancel = 1'b0;
    logic       buzzer, busy, done;

    int checks = 0;
    int passes = 0;
    logic [2:0] exp_q[$];

    beep_sequencer #(.ON_CYCLES(4), .OFF_CYCLES(3), .TONE_HALF(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .count  (count),
        .cancel (cancel),
        .buzzer (buzzer),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] req);
        checks++;
        assert (obs === req) passes++;
        else $error("FAIL %s: {buzzer,busy,done} observed %b expected %b", tag, obs, req);
    endtask

    task automatic push(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // One ON phase of n cycles: tone alternates 1,0,... with TONE_HALF=1
    task automatic push_on(input int n);
        for (int i = 0; i < n; i++) begin
`ifdef BEEP_TONE_EN
            exp_q.push_back({(i % 2 == 0), 2'b10});
`else
            exp_q.push_back(3'b110);
`endif
        end
    endtask

    // Drive inputs for the next edge, then sample the resulting cycle on the following negedge
    task automatic tick(input string tag, input logic s, input logic [3:0] c, input logic x);
        start = s; count = c; cancel = x;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s: scoreboard underflow, observed %b expected none", tag, {buzzer, busy, done});
        end else begin
            check(tag, {buzzer, busy, done}, exp_q.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) tick(tag, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset", {buzzer, busy, done}, 3'b000);
        rst = 1'b1;
        push(3'b000, 2);
        drain("idle_after_reset");

        push_on(4); push(3'b001, 1); push(3'b000, 1);
        tick("one_beep", 1'b1, 4'd1, 1'b0);
        drain("one_beep");

        push_on(4); push(3'b010, 3); push_on(4); push(3'b010, 3); push_on(4); push(3'b001, 1); push(3'b000, 1);
        tick("three_beeps", 1'b1, 4'd3, 1'b0);
        drain("three_beeps");

        push(3'b000, 3);
        tick("zero_count", 1'b1, 4'd0, 1'b0);
        drain("zero_count");

        push_on(4); push(3'b010, 3); push_on(4); push(3'b010, 3); push_on(4); push(3'b001, 1);
        push_on(4); push(3'b001, 1); push(3'b000, 1);
        tick("restart_ignored", 1'b1, 4'd3, 1'b0);
        for (int i = 1; i <= 18; i++) tick("restart_ignored", i == 6, (i == 6) ? 4'd5 : 4'd0, 1'b0);
        tick("start_in_done", 1'b1, 4'd1, 1'b0);
        drain("start_in_done");

        push_on(2); push(3'b000, 4);
        tick("cancel", 1'b1, 4'd2, 1'b0);
        tick("cancel", 1'b0, 4'd0, 1'b0);
        tick("cancel", 1'b0, 4'd0, 1'b1);
        drain("cancel");

        push(3'b000, 3);
        tick("start_cancel_idle", 1'b1, 4'd2, 1'b1);
        drain("start_cancel_idle");

        push(3'b000, 2);
        tick("cancel_in_idle", 1'b0, 4'd0, 1'b1);
        drain("cancel_in_idle");

        push_on(4); push(3'b010, 1);
        tick("reset_mid_off", 1'b1, 4'd2, 1'b0);
        drain("reset_mid_off");
        #2 rst = 1'b0;
        #1 check("async_reset", {buzzer, busy, done}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        push(3'b000, 4);
        drain("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
